regfile_context_seq: RTL and testbench

- Context save/restore sequencer for the 16x8 register file.
- On request, it copies every register to a memory save area or reloads every register from it, one register at a time. Intended use: interrupt entry/exit and debug snapshots.
- Owns the register file's write port and read port A while active. When idle, it passes the CPU's accesses straight through.

---
 rtl/regfile_context_seq.sv | 141 ++++++++++++++
 tb/tb_regfile_context_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_context_seq.sv
// regfile_context_seq: walks the 16x8 register file to save it to memory or restore it from memory.
// Optional build macro CTX_CHECKSUM_EN adds an XOR checksum word after the save area and the ctx_err output.
module regfile_context_seq #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int MEM_AW = 8,
    parameter logic [MEM_AW-1:0] SAVE_BASE = 8'hF0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_save,
    input  logic              start_restore,
    output logic              busy,
    output logic              done,
    output logic              cpu_stall,
    input  logic [ADDR_W-1:0] cpu_read_addr_A,
    input  logic [ADDR_W-1:0] cpu_write_addr,
    input  logic [DATA_W-1:0] cpu_write_data,
    input  logic              cpu_write_enable,
    output logic [ADDR_W-1:0] rf_read_addr_A,
    input  logic [DATA_W-1:0] rf_read_data_A,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef CTX_CHECKSUM_EN
    output logic              ctx_err,
`endif
    input  logic              mem_ack
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SAVE_LD  = 3'd1;
    localparam logic [2:0] SAVE_REQ = 3'd2;
    localparam logic [2:0] RST_REQ  = 3'd3;
    localparam logic [2:0] RST_WR   = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;
    localparam logic [2:0] SAVE_CK  = 3'd6;
    localparam logic [2:0] RST_CK   = 3'd7;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
`ifdef CTX_CHECKSUM_EN
    localparam logic [2:0] SAVE_END = SAVE_CK;
    localparam logic [2:0] RST_END  = RST_CK;
    localparam logic [MEM_AW-1:0] CK_ADDR = SAVE_BASE + MEM_AW'(NUM_REGS);
`else
    localparam logic [2:0] SAVE_END = DONE;
    localparam logic [2:0] RST_END  = DONE;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    // Sequencer next state: one register per LD/REQ (save) or REQ/WR (restore) pair.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                idx_d   = '0;
                state_d = start_save ? SAVE_LD : start_restore ? RST_REQ : IDLE;
            end
            SAVE_LD: begin
                buf_d   = rf_read_data_A;
                state_d = SAVE_REQ;
            end
            SAVE_REQ: if (mem_ack) begin
                state_d = (idx_q == LAST) ? SAVE_END : SAVE_LD;
                idx_d   = (idx_q == LAST) ? idx_q : idx_q + ADDR_W'(1);
            end
            RST_REQ: if (mem_ack) begin
                buf_d   = mem_rdata;
                state_d = RST_WR;
            end
            RST_WR: begin
                state_d = (idx_q == LAST) ? RST_END : RST_REQ;
                idx_d   = (idx_q == LAST) ? idx_q : idx_q + ADDR_W'(1);
            end
            SAVE_CK, RST_CK: state_d = mem_ack ? DONE : state_q;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

`ifdef CTX_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
    logic              err_q;

    // XOR checksum over transferred words; mismatch flagged when the stored checksum is read back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else if (state_q == IDLE && (start_save || start_restore)) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else if ((state_q == SAVE_REQ && mem_ack) || state_q == RST_WR) begin
            csum_q <= csum_q ^ buf_q;
        end else if (state_q == RST_CK && mem_ack) begin
            err_q  <= mem_rdata != csum_q;
        end
    end

    assign ctx_err   = err_q;
    assign mem_addr  = (state_q == SAVE_CK || state_q == RST_CK) ? CK_ADDR : SAVE_BASE + MEM_AW'(idx_q);
    assign mem_wdata = (state_q == SAVE_CK) ? csum_q : buf_q;
`else
    assign mem_addr  = SAVE_BASE + MEM_AW'(idx_q);
    assign mem_wdata = buf_q;
`endif

    // Decoded outputs and the CPU pass-through mux; the sequencer owns the register file while busy.
    always_comb begin
        busy            = state_q != IDLE;
        done            = state_q == DONE;
        cpu_stall       = busy;
        mem_req         = state_q == SAVE_REQ || state_q == RST_REQ || state_q == SAVE_CK || state_q == RST_CK;
        mem_we          = state_q == SAVE_REQ || state_q == SAVE_CK;
        rf_read_addr_A  = busy ? idx_q : cpu_read_addr_A;
        rf_write_addr   = busy ? idx_q : cpu_write_addr;
        rf_write_data   = busy ? buf_q : cpu_write_data;
        rf_write_enable = busy ? state_q == RST_WR : cpu_write_enable;
    end
endmodule

// File: tb/tb_regfile_context_seq.sv
// tb_regfile_context_seq: randomized self-checking bench with register file and memory models.
module tb_regfile_context_seq;
    localparam int N = 16;
    localparam logic [7:0] BASE = 8'hF0;
`ifdef CTX_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_save = 1'b0, start_restore = 1'b0;
    logic busy, done, cpu_stall;
    logic [3:0] cpu_read_addr_A = '0, cpu_write_addr = '0;
    logic [7:0] cpu_write_data = '0;
    logic cpu_write_enable = 1'b0;
    logic [3:0] rf_read_addr_A, rf_write_addr;
    logic [7:0] rf_read_data_A, rf_write_data;
    logic rf_write_enable;
    logic mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CTX_CHECKSUM_EN
    logic ctx_err;
`endif

    logic [7:0] rf [N];
    logic [7:0] mem [256];
    logic [15:0] wlog [$];
    int delay = 0;
    int wcnt = 0;
    int tests = 0;
    int fails = 0;
    int done_total = 0;
    int stab_err = 0;
    logic hold = 1'b0;
    logic [16:0] held;
    logic pl_we = 1'b0;
    logic [7:0] pl_addr = '0, pl_data = '0;

    regfile_context_seq dut (
        .clk(clk), .reset(reset),
        .start_save(start_save), .start_restore(start_restore),
        .busy(busy), .done(done), .cpu_stall(cpu_stall),
        .cpu_read_addr_A(cpu_read_addr_A), .cpu_write_addr(cpu_write_addr),
        .cpu_write_data(cpu_write_data), .cpu_write_enable(cpu_write_enable),
        .rf_read_addr_A(rf_read_addr_A), .rf_read_data_A(rf_read_data_A),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef CTX_CHECKSUM_EN
        .ctx_err(ctx_err),
`endif
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    assign rf_read_data_A = rf[rf_read_addr_A];
    assign mem_rdata = mem[mem_addr];
    assign mem_ack = mem_req && (wcnt == delay);

    always @(posedge clk) begin
        if (rf_write_enable) rf[rf_write_addr] <= rf_write_data;
        if (pl_we) mem[pl_addr] <= pl_data;
        if (mem_req && mem_ack) begin
            wcnt <= 0;
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wlog.push_back({mem_addr, mem_wdata});
            end
        end else if (mem_req) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (hold && (!mem_req || {mem_we, mem_addr, mem_wdata} != held)) stab_err <= stab_err + 1;
        hold <= mem_req && !mem_ack;
        held <= {mem_we, mem_addr, mem_wdata};
    end

    always @(negedge clk) if (done) done_total <= done_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_write_addr = a; cpu_write_data = d; cpu_write_enable = 1'b1;
        @(negedge clk);
        cpu_write_enable = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_addr = a; pl_data = d; pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic run(input bit s, input bit r, input int pulse_at,
                       output int bcnt, output int dcnt, output int dat,
                       output bit stall_seen, output bit we_seen);
        bcnt = 0; dcnt = 0; dat = -1; stall_seen = 0; we_seen = 0;
        @(negedge clk);
        start_save = s; start_restore = r;
        @(negedge clk);
        start_save = 1'b0; start_restore = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!busy) break;
            bcnt++;
            if (done) begin dcnt++; dat = bcnt; end
            if (c == pulse_at) begin
                start_restore = 1'b1;
                cpu_write_addr = 4'd3; cpu_write_data = 8'h77; cpu_write_enable = 1'b1;
                #1;
                stall_seen = cpu_stall; we_seen = rf_write_enable;
            end
            @(negedge clk);
            start_restore = 1'b0; cpu_write_enable = 1'b0;
        end
        check("seq_terminated", busy, 0);
    endtask

    function automatic int exp_busy(input int d);
        return N * (2 + d) + 1 + CK * (1 + d);
    endfunction

    int bc, dc, da, base, cnt;
    bit st, we;
    logic [7:0] img [N];
    logic [7:0] ck;

    initial begin
        cpu_write_addr = 4'd5;
        cpu_read_addr_A = 4'd9;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rf_we", rf_write_enable, 0);
        check("rst_rf_waddr", rf_write_addr, 5);
        check("rst_rf_raddr", rf_read_addr_A, 9);
        reset = 1'b1;

        // save, zero-wait memory, registers 10+r
        for (int r = 0; r < N; r++) cpu_wr(4'(r), 8'h10 + 8'(r));
        delay = 0;
        base = wlog.size();
        run(1, 0, -1, bc, dc, da, st, we);
        check("save_busy_cycles", bc, exp_busy(0));
        check("save_done_count", dc, 1);
        check("save_done_last", da, bc);
        check("save_write_count", wlog.size() - base, N + CK);
        for (int i = 0; i < N; i++)
            check($sformatf("save_wr%0d", i), wlog[base + i], {8'(BASE + 8'(i)), 8'h10 + 8'(i)});
`ifdef CTX_CHECKSUM_EN
        check("save_ck_write", wlog[base + N], 16'h0000);
        poke(8'hF5, 8'h99);
        delay = 1;
        run(0, 1, -1, bc, dc, da, st, we);
        check("ck_corrupt_err", ctx_err, 1);
        check("ck_corrupt_rf5", rf[5], 8'h99);
`endif

        // restore with 2-cycle ack delay
        for (int i = 0; i < N; i++) poke(8'(BASE + 8'(i)), 8'hA0 + 8'(i));
        poke(8'(BASE + 8'(N)), 8'h00);
        delay = 2;
        run(0, 1, -1, bc, dc, da, st, we);
        check("rst_busy_cycles", bc, exp_busy(2));
        check("rst_done_count", dc, 1);
        for (int i = 0; i < N; i++) check($sformatf("rst_rf%0d", i), rf[i], 8'hA0 + 8'(i));
        check("rst_req_stable", stab_err, 0);
`ifdef CTX_CHECKSUM_EN
        check("ck_clean_err", ctx_err, 0);
`endif

        // idle pass-through, then simultaneous starts with restore and CPU write mid-save
        cpu_wr(4'd3, 8'h55);
        check("idle_wr_lands", rf[3], 8'h55);
        cpu_read_addr_A = 4'd7;
        #1;
        check("idle_raddr", rf_read_addr_A, 7);
        delay = 0;
        base = wlog.size();
        run(1, 1, 5, bc, dc, da, st, we);
        check("both_save_writes", wlog.size() - base, N + CK);
        check("both_busy_cycles", bc, exp_busy(0));
        check("busy_stall", st, 1);
        check("busy_wr_blocked", we, 0);
        check("busy_wr_r3", rf[3], 8'h55);
        cnt = 0;
        repeat (10) begin @(negedge clk); if (busy) cnt++; end
        check("no_second_seq", cnt, 0);

        // reset at idx 7 of a save
        poke(8'hF7, 8'h5A);
        dc = done_total;
        base = wlog.size();
        @(negedge clk); start_save = 1'b1;
        @(negedge clk); start_save = 1'b0;
        for (int c = 0; c < 200 && wlog.size() < base + 7; c++) @(negedge clk);
        check("mid_reached_idx7", wlog.size() - base, 7);
        reset = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_mem_req", mem_req, 0);
        check("mid_mem_wdata", mem_wdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_f6_written", mem[8'hF6], rf[6]);
        check("mid_f7_untouched", mem[8'hF7], 8'h5A);
        check("mid_no_done", done_total, dc);

        // randomized save / scramble / restore rounds
        for (int k = 0; k < 4; k++) begin
            ck = 0;
            for (int r = 0; r < N; r++) begin
                img[r] = 8'($urandom);
                ck ^= img[r];
                cpu_wr(4'(r), img[r]);
            end
            delay = $urandom_range(0, 3);
            run(1, 0, -1, bc, dc, da, st, we);
            check($sformatf("rnd%0d_save_busy", k), bc, exp_busy(delay));
            cnt = 0;
            for (int i = 0; i < N; i++) if (mem[8'(BASE + 8'(i))] !== img[i]) cnt++;
            check($sformatf("rnd%0d_mem_image", k), cnt, 0);
`ifdef CTX_CHECKSUM_EN
            check($sformatf("rnd%0d_ck_word", k), mem[8'(BASE + 8'(N))], ck);
`endif
            for (int r = 0; r < N; r++) cpu_wr(4'(r), ~img[r]);
            delay = $urandom_range(0, 3);
            run(0, 1, -1, bc, dc, da, st, we);
            check($sformatf("rnd%0d_rst_busy", k), bc, exp_busy(delay));
            cnt = 0;
            for (int i = 0; i < N; i++) if (rf[i] !== img[i]) cnt++;
            check($sformatf("rnd%0d_rf_image", k), cnt, 0);
`ifdef CTX_CHECKSUM_EN
            check($sformatf("rnd%0d_ck_err", k), ctx_err, 0);
`endif
        end
        check("final_req_stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
